// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx between NUM_REQ byte sources.
// Optional packet lock (req_last framing) enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACT_TIMEOUT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_active,
  output logic                 o_busy,
  output logic                 o_err_timeout
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACT, S_WAIT_DONE, S_HOLDOFF} state_t;

  state_t               r_state, w_next;
  logic [PW-1:0]        r_rr_ptr;
  logic [3:0]           r_cnt;
  logic [NUM_REQ-1:0]   r_grant;
  logic [7:0]           r_byte;
  logic [NUM_REQ-1:0]   w_elig;
  logic [PW-1:0]        w_win;
  logic                 w_found, w_xfer, w_timeout;
  int                   w_idx;

`ifdef UART_ARB_LOCK_EN
  logic r_lock;

  // While a packet is open only its owner (last winner) may transfer.
  always_comb begin
    w_elig = i_req_valid;
    if (r_lock) w_elig = i_req_valid & (NUM_REQ'(1) << r_rr_ptr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_lock <= 1'b0;
    else if (w_xfer)    r_lock <= ~i_req_last[w_win];
    else if (w_timeout) r_lock <= 1'b0;
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^i_req_last;
  assign w_elig        = i_req_valid;
`endif

  // Search starts just after the previous winner and wraps modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && w_elig[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PW-1:0];
      end
    end
  end

  assign w_xfer        = (r_state == S_IDLE) && !i_tx_active && w_found;
  assign w_timeout     = (r_state == S_WAIT_ACT) && !i_tx_active && (r_cnt == 4'(ACT_TIMEOUT - 1));
  assign o_req_ready   = w_xfer ? (NUM_REQ'(1) << w_win) : '0;
  assign o_grant       = r_grant;
  assign o_tx_byte     = r_byte;
  assign o_tx_dv       = (r_state == S_ISSUE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_err_timeout = w_timeout;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_xfer) w_next = S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_ACT;
      S_WAIT_ACT:  if (i_tx_active) w_next = S_WAIT_DONE;
                   else if (w_timeout) w_next = S_IDLE;
      S_WAIT_DONE: if (!i_tx_active) w_next = S_HOLDOFF;
      S_HOLDOFF:   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= PW'(NUM_REQ - 1);
      r_cnt    <= '0;
      r_grant  <= '0;
      r_byte   <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_byte   <= i_req_data[{w_win, 3'b000} +: 8];
        r_grant  <= NUM_REQ'(1) << w_win;
        r_rr_ptr <= w_win;
      end
      // A dropped byte and a finished frame both release ownership.
      if (r_state == S_HOLDOFF || w_timeout) r_grant <= '0;
      if (r_state == S_WAIT_ACT) r_cnt <= r_cnt + 4'd1;
      else                       r_cnt <= '0;
    end
  end
endmodule
